// File: rtl/sub16_seq_pkg.sv
// Shared defaults and state type for the slice-serial subtractor.
package sub16_seq_pkg;

  localparam int WIDTH_DEF = 16;
  localparam int SLICE_DEF = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/sub16_seq_if.sv
// Request/result bundle of the slice-serial subtractor.
interface sub16_seq_if #(
    parameter int WIDTH = 16
);

    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             bi;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] d;
    logic             bo;
    logic             ovf;
    logic             zero;

    modport master (
        output start, a, b, bi,
        input  busy, done, d, bo, ovf, zero
    );

    modport slave (
        input  start, a, b, bi,
        output busy, done, d, bo, ovf, zero
    );

endinterface

// File: rtl/sub16_seq_sub4_bla.sv
// One slice of the subtractor: x - y - bin with borrow lookahead terms.
module sub4_bla #(
    parameter int W = 4
) (
    input  logic [W-1:0] x,
    input  logic [W-1:0] y,
    input  logic         bin,
    output logic [W-1:0] diff,
    output logic         bout
);

    logic [W-1:0] g;
    logic [W-1:0] p;
    logic [W:0]   c;

    // g: this bit borrows on its own; p: this bit passes an incoming borrow
    assign g = ~x & y;
    assign p = ~(x ^ y);

    always_comb begin
        c    = '0;
        c[0] = bin;
        for (int i = 0; i < W; i++) begin
            c[i+1] = g[i] | (p[i] & c[i]);
        end
    end

    assign diff = x ^ y ^ c[W-1:0];
    assign bout = c[W];

endmodule

// File: rtl/sub16_seq.sv
// Slice-serial subtractor: a - b - bi computed SLICE bits per clock.
module sub16_seq
    import sub16_seq_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int SLICE = SLICE_DEF
) (
    input  logic        clk,
    input  logic        reset_n,
    sub16_seq_if.slave  bus
);

    localparam int N  = WIDTH / SLICE;
    localparam int KW = (N > 1) ? $clog2(N) : 1;

    state_t           state;
    state_t           state_nx;
    logic             accept;
    logic             last;
    logic [KW-1:0]    k;
    logic [WIDTH-1:0] ra;
    logic [WIDTH-1:0] rb;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] acc_nx;
    logic             brw;
    logic [SLICE-1:0] sx;
    logic [SLICE-1:0] sy;
    logic [SLICE-1:0] sd;
    logic             sbo;
    logic [WIDTH-1:0] d_q;
    logic             bo_q;
    logic             ovf_q;
    logic             zero_q;

    assign last = (k == KW'(N - 1));
    assign sx   = ra[k*SLICE +: SLICE];
    assign sy   = rb[k*SLICE +: SLICE];

    sub4_bla #(
        .W (SLICE)
    ) u_bla (
        .x    (sx),
        .y    (sy),
        .bin  (brw),
        .diff (sd),
        .bout (sbo)
    );

    // Partial slices collect here so d only moves on the final slice
    always_comb begin
        acc_nx                    = acc;
        acc_nx[k*SLICE +: SLICE]  = sd;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        accept   = 1'b0;
        unique case (state)
            IDLE: begin
                if (bus.start) begin
                    accept   = 1'b1;
                    state_nx = CALC;
                end
            end
            CALC: begin
                if (last) begin
                    state_nx = DONE;
                end
            end
            DONE: begin
                if (bus.start) begin
                    accept   = 1'b1;
                    state_nx = CALC;
                end else begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            k      <= '0;
            ra     <= '0;
            rb     <= '0;
            acc    <= '0;
            brw    <= 1'b0;
            d_q    <= '0;
            bo_q   <= 1'b0;
            ovf_q  <= 1'b0;
            zero_q <= 1'b0;
        end else if (accept) begin
            ra  <= bus.a;
            rb  <= bus.b;
            brw <= bus.bi;
            k   <= '0;
        end else if (state == CALC) begin
            acc <= acc_nx;
            brw <= sbo;
            k   <= k + KW'(1);
            if (last) begin
                k      <= '0;
                d_q    <= acc_nx;
                bo_q   <= sbo;
                ovf_q  <= (ra[WIDTH-1] ^ rb[WIDTH-1]) &
                          (acc_nx[WIDTH-1] ^ ra[WIDTH-1]);
                zero_q <= (acc_nx == '0);
            end
        end
    end

    assign bus.busy = (state == CALC);
    assign bus.done = (state == DONE);
    assign bus.d    = d_q;
    assign bus.bo   = bo_q;
    assign bus.ovf  = ovf_q;
    assign bus.zero = zero_q;

endmodule

// File: tb/tb_sub16_seq.sv
// Directed self-checking bench for sub16_seq.
module tb_sub16_seq;
    import sub16_seq_pkg::*;

    logic clk;
    logic reset_n;
    int   n_chk;
    int   n_err;
    int   lat;
    int   seen;

    sub16_seq_if #(.WIDTH(16)) bus ();

    sub16_seq #(
        .WIDTH (16),
        .SLICE (4)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic launch(input logic [15:0] av, input logic [15:0] bv,
                          input logic biv);
        @(negedge clk);
        bus.start = 1'b1;
        bus.a     = av;
        bus.b     = bv;
        bus.bi    = biv;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.a     = ~av;
        bus.b     = ~bv;
        bus.bi    = ~biv;
    endtask

    // Counts edges after capture until done, bounded
    task automatic wait_done(input logic [15:0] prev, output int n);
        n = 0;
        while (!bus.done && n < 12) begin
            @(posedge clk);
            #1;
            n++;
            if (n == 2) chk("hold_d", bus.d, prev);
        end
    endtask

    task automatic run_op(input string tag, input logic [15:0] av,
                          input logic [15:0] bv, input logic biv,
                          input logic [15:0] ed, input logic ebo,
                          input logic eovf, input logic ez);
        logic [15:0] prev;
        int n;
        prev = bus.d;
        launch(av, bv, biv);
        chk({tag, "_busy"}, bus.busy, 1);
        wait_done(prev, n);
        chk({tag, "_lat"}, n, 4);
        chk({tag, "_d"}, bus.d, ed);
        chk({tag, "_bo"}, bus.bo, ebo);
        chk({tag, "_ovf"}, bus.ovf, eovf);
        chk({tag, "_zero"}, bus.zero, ez);
    endtask

    initial begin
        n_chk     = 0;
        n_err     = 0;
        reset_n   = 1'b0;
        bus.start = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        bus.bi    = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", bus.busy, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_d", bus.d, 0);
        chk("rst_flags", {bus.bo, bus.ovf, bus.zero}, 0);
        @(negedge clk);
        reset_n = 1'b1;

        run_op("v1", 16'h0005, 16'h0003, 1'b0, 16'h0002, 0, 0, 0);
        @(posedge clk);
        #1;
        chk("done_1cyc", bus.done, 0);
        run_op("v2", 16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1, 0, 0);
        run_op("v3", 16'h8000, 16'h0001, 1'b0, 16'h7FFF, 0, 1, 0);
        run_op("v4", 16'h1234, 16'h1233, 1'b1, 16'h0000, 0, 0, 1);
        run_op("v5", 16'h0000, 16'h0000, 1'b1, 16'hFFFF, 1, 0, 0);

        // Starts during CALC must be ignored
        @(posedge clk);
        #1;
        launch(16'h00F0, 16'h000F, 1'b0);
        bus.start = 1'b1;
        bus.a     = 16'hFFFF;
        bus.b     = 16'h0000;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        @(posedge clk);
        #1;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        chk("ign_busy", bus.busy, 1);
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        chk("ign_done", bus.done, 1);
        chk("ign_d", bus.d, 16'h00E1);
        chk("ign_bo", bus.bo, 0);

        // Back-to-back start accepted in the DONE cycle
        run_op("b2b_a", 16'h0010, 16'h0001, 1'b0, 16'h000F, 0, 0, 0);
        run_op("b2b_b", 16'h7FFF, 16'hFFFF, 1'b0, 16'h8000, 1, 1, 0);

        // Abort in the second CALC cycle
        @(posedge clk);
        #1;
        launch(16'h1111, 16'h0001, 1'b0);
        @(posedge clk);
        #1;
        reset_n = 1'b0;
        #1;
        chk("abort_d", bus.d, 0);
        chk("abort_busy", bus.busy, 0);
        chk("abort_done", bus.done, 0);
        chk("abort_flags", {bus.bo, bus.ovf, bus.zero}, 0);
        seen = 0;
        repeat (3) begin
            @(posedge clk);
            #1;
            if (bus.done) seen++;
        end
        @(negedge clk);
        reset_n = 1'b1;
        repeat (6) begin
            @(posedge clk);
            #1;
            if (bus.done) seen++;
        end
        chk("abort_nodone", seen, 0);
        run_op("post_rst", 16'hFFFF, 16'hFFFF, 1'b0, 16'h0000, 0, 0, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

    initial begin
        lat = 0;
        #200000;
        $display("FAIL timeout got=%0d exp=%0d", lat, 1);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/sub16_seq.md
SUB16_SEQ -- requirements
Module: sub16_seq

Interface
REQ-001 SHALL have parameter WIDTH, default 16, operand/result width in bits.
REQ-002 SHALL have parameter SLICE, default 4, bits processed per cycle; WIDTH SHALL be a multiple of SLICE.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port start  input  1  request a subtraction; sampled on the rising clk edge.
REQ-006 SHALL have port a  input  WIDTH  minuend; captured when start is accepted.
REQ-007 SHALL have port b  input  WIDTH  subtrahend; captured when start is accepted.
REQ-008 SHALL have port bi  input  1  borrow-in; captured when start is accepted.
REQ-009 SHALL have port busy  output  1  high while slices are being computed.
REQ-010 SHALL have port done  output  1  one-cycle pulse marking valid results.
REQ-011 SHALL have port d  output  WIDTH  difference a - b - bi, modulo 2^WIDTH.
REQ-012 SHALL have port bo  output  1  borrow-out; 1 when a < b + bi (unsigned).
REQ-013 SHALL have port ovf  output  1  signed overflow: (a[MSB]^b[MSB]) & (d[MSB]^a[MSB]).
REQ-014 SHALL have port zero  output  1  1 when d == 0.

Function
REQ-015 SHALL implement FSM states IDLE, CALC, DONE.
REQ-016 In IDLE or DONE with start=1, SHALL latch a, b and bi, clear the slice counter, and enter CALC.
REQ-017 In CALC, each edge SHALL compute slice k = a[k] - b[k] - borrow, store its SLICE result bits, update the internal borrow register, and increment k.
REQ-018 Borrow into slice 0 SHALL be the latched bi; borrow into slice k>0 SHALL be the borrow-out of slice k-1.
REQ-019 On the edge computing the last slice (k = WIDTH/SLICE-1), SHALL load d, bo, ovf and zero together and enter DONE.
REQ-020 done SHALL be 1 only in DONE, exactly one cycle; DONE SHALL return to IDLE unless start=1.
REQ-021 Latency: with defaults, done SHALL be high in the cycle after the 4th edge following the start-capture edge.
REQ-022 busy SHALL equal (state == CALC).
REQ-023 start while in CALC SHALL be ignored; operands and progress SHALL be unaffected.
REQ-024 start in the DONE cycle SHALL be accepted (back-to-back); done still pulses for that cycle.
REQ-025 d, bo, ovf and zero SHALL hold their values from their last load until the next final-slice edge; intermediate slices SHALL NOT appear on d.
REQ-026 Changes on a, b or bi after capture SHALL NOT affect the result.

Reset
REQ-027 reset_n=0 SHALL asynchronously force IDLE, counter=0, borrow register=0, internal operands=0, busy=0, done=0, d=0, bo=0, ovf=0, zero=0.
REQ-028 reset_n asserted mid-CALC SHALL abort the operation without producing a done pulse.
REQ-029 The first start after reset_n deasserts SHALL be processed normally.

Structure
REQ-030 A shared package SHALL hold the WIDTH/SLICE defaults and the FSM state type (IDLE, CALC, DONE).
REQ-031 The SLICE-bit borrow-lookahead subtract stage SHALL be a separate combinational sub-module named sub4_bla (inputs x, y, bin; outputs diff, bout).

Verification
REQ-032 a=0x0005, b=0x0003, bi=0 -> d=0x0002, bo=0, ovf=0, zero=0; done high in the cycle after the 4th edge after capture.
REQ-033 a=0x0000, b=0x0001, bi=0 -> d=0xFFFF, bo=1, ovf=0, zero=0.
REQ-034 a=0x8000, b=0x0001, bi=0 -> d=0x7FFF, ovf=1, bo=0.
REQ-035 a=0x1234, b=0x1233, bi=1 -> d=0x0000, zero=1, bo=0.
REQ-036 start pulsed twice in CALC with new operands -> ignored, first result correct; start in DONE cycle -> second result follows 4 edges later.
REQ-037 reset_n low during the 2nd CALC cycle -> all outputs 0 immediately, no done pulse; the next operation, a=0xFFFF, b=0xFFFF, bi=0, gives d=0x0000 and zero=1.
